// File: rtl/bcd_seg_scan_if.sv
// Bus between the BCD converter/host and the 7-segment scanner.
// Digits and load strobe flow in; segment, anode and slot tick flow out.
interface bcd_seg_scan_if;
  logic       load;
  logic [3:0] dig_hund;
  logic [3:0] dig_tens;
  logic [3:0] dig_ones;
  logic [6:0] seg;
  logic [2:0] an;
  logic       slot_tick;

  modport master (
    output load, dig_hund, dig_tens, dig_ones,
    input  seg, an, slot_tick
  );

  modport slave (
    input  load, dig_hund, dig_tens, dig_ones,
    output seg, an, slot_tick
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit 7-segment driver with dead-time blanking,
// leading-zero suppression and a dash for non-BCD nibbles.
module bcd_seg_scan #(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned DEAD       = 2,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seg_scan_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam logic [6:0]  SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0]  AN_OFF  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } dig_e;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  dig_e             idx, idx_nxt;
  logic [3:0]       sh_hund, sh_tens, sh_ones;
  logic [6:0]       seg_q, seg_nxt;
  logic [2:0]       an_q, an_nxt;
  logic             tick_q, tick_nxt;

  logic [3:0]       digit;
  logic             blank;
  logic [6:0]       seg_on;
  logic [2:0]       an_on;

  // Segment pattern {g..a}, active-high; anything above 9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= DIG_ONES;
      sh_hund <= '0;
      sh_tens <= '0;
      sh_ones <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      seg_q  <= seg_nxt;
      an_q   <= an_nxt;
      tick_q <= tick_nxt;
      if (bus.load) begin
        sh_hund <= bus.dig_hund;
        sh_tens <= bus.dig_tens;
        sh_ones <= bus.dig_ones;
      end
    end
  end

  // Prescaler, digit sequencing and output decode from current state.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    idx_nxt = idx;
    digit   = sh_ones;
    blank   = 1'b0;
    an_on   = 3'b000;

    if (cnt == CNT_W'(CLK_DIV - 1)) begin
      cnt_nxt = '0;
      case (idx)
        DIG_ONES: idx_nxt = DIG_TENS;
        DIG_TENS: idx_nxt = DIG_HUND;
        default:  idx_nxt = DIG_ONES;
      endcase
    end
    tick_nxt = (cnt_nxt == CNT_W'(CLK_DIV - 1));

    case (idx)
      DIG_ONES: begin
        digit = sh_ones;
        an_on = 3'b001;
      end
      DIG_TENS: begin
        digit = sh_tens;
        blank = (BLANK_LZ != 0) && (sh_hund == 4'd0) && (sh_tens == 4'd0);
        an_on = 3'b010;
      end
      DIG_HUND: begin
        digit = sh_hund;
        blank = (BLANK_LZ != 0) && (sh_hund == 4'd0);
        an_on = 3'b100;
      end
      default: ;
    endcase

    seg_on = blank ? 7'b0000000 : decode(digit);

    // Dead time at the head of each slot suppresses ghosting.
    if (cnt < CNT_W'(DEAD)) begin
      seg_on = 7'b0000000;
      an_on  = 3'b000;
    end

    seg_nxt = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    an_nxt  = (ACTIVE_LOW != 0) ? ~an_on  : an_on;
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.slot_tick = tick_q;

endmodule
